// File: rtl/i2c_txn_arbiter.sv
// Round-robin sequencer sharing one i2c_master between two burst requesters.
// Grants the bus, drives the master handshake, streams bytes and reports done/timeout.
module i2c_txn_arbiter #(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [13:0]        req_addr,
  input  logic [1:0]         req_rw,
  input  logic [2*LEN_W-1:0] req_len,
  input  logic [15:0]        req_wdata,
  output logic [1:0]         gnt,
  output logic [1:0]         wr_next,
  output logic [7:0]         rd_data,
  output logic [1:0]         rd_valid,
  output logic [1:0]         done,
  output logic [1:0]         err,
  output logic               busy,
  output logic [6:0]         addr,
  output logic               rw,
  output logic [7:0]         tx_data,
  output logic               i2c_en,
  output logic               data_valid,
  output logic               read_last,
  input  logic               data_next,
  input  logic [7:0]         rx_data,
  input  logic               ready
);

  // Master handshake: i2c_en is offered while ready is high and withdrawn
  // once ready drops; each data_next pulse retires exactly one byte.
  typedef enum logic [1:0] {IDLE, START, XFER, WAIT_RDY} state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic             g;
  logic             prio;
  logic [LEN_W-1:0] rem;
  logic [WD_W-1:0]  wdog;
  logic [6:0]       addr_r;
  logic             rw_r;
  logic             pick;
  logic             wd_expire;
  logic             finish_ok;
  logic             in_xfer;

  // With both requesting, the favoured one wins; otherwise the lone requester.
  always_comb begin
    pick = (req == 2'b11) ? prio : req[1];
  end

  assign wd_expire  = (state != IDLE) && (wdog == WD_LAST);
  assign finish_ok  = (state == WAIT_RDY) && ready;
  assign in_xfer    = (state == START) || (state == XFER);
  assign busy       = (state != IDLE);
  assign addr       = addr_r;
  assign rw         = rw_r;
  assign data_valid = in_xfer && (rem != '0);
  assign read_last  = in_xfer && rw_r && (rem == '0);
  assign wr_next    = ((state == XFER) && data_next && !rw_r && !wd_expire) ? gnt : 2'b00;
  assign tx_data    = gnt[0] ? req_wdata[7:0] : (gnt[1] ? req_wdata[15:8] : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      g        <= 1'b0;
      prio     <= 1'b0;
      rem      <= '0;
      wdog     <= '0;
      addr_r   <= 7'h00;
      rw_r     <= 1'b0;
      i2c_en   <= 1'b0;
      rd_data  <= 8'h00;
      rd_valid <= 2'b00;
      done     <= 2'b00;
      err      <= 2'b00;
    end else begin
      rd_valid <= 2'b00;
      done     <= 2'b00;
      err      <= 2'b00;
      if (wd_expire || finish_ok) begin
        // Normal completion and abort share the same teardown.
        done   <= wd_expire ? 2'b00 : gnt;
        err    <= wd_expire ? gnt : 2'b00;
        state  <= IDLE;
        gnt    <= 2'b00;
        prio   <= ~g;
        addr_r <= 7'h00;
        rw_r   <= 1'b0;
        rem    <= '0;
        wdog   <= '0;
        i2c_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            wdog <= '0;
            if (ready && (req != 2'b00)) begin
              g      <= pick;
              gnt    <= pick ? 2'b10 : 2'b01;
              addr_r <= pick ? req_addr[13:7] : req_addr[6:0];
              rw_r   <= req_rw[pick];
              rem    <= pick ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
              i2c_en <= 1'b1;
              state  <= START;
            end
          end
          START: begin
            if (!ready) begin
              i2c_en <= 1'b0;
              state  <= XFER;
              wdog   <= '0;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          XFER: begin
            if (data_next) begin
              wdog <= '0;
              if (rw_r) begin
                rd_data  <= rx_data;
                rd_valid <= gnt;
              end
              if (rem == '0) state <= WAIT_RDY;
              else           rem   <= rem - 1'b1;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          WAIT_RDY: wdog <= wdog + 1'b1;
          default:  state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: behavioural i2c master/slave model plus
// per-scenario tasks checking outputs against scoreboard queues.
module tb_i2c_txn_arbiter;
  localparam int LEN_W = 4;
  localparam int TO    = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [13:0]  req_addr;
  logic [1:0]   req_rw;
  logic [7:0]   req_len;
  logic [15:0]  req_wdata;
  logic [1:0]   gnt, wr_next, rd_valid, done, err;
  logic [7:0]   rd_data, tx_data, rx_data;
  logic         busy, rw, i2c_en, data_valid, read_last, data_next, ready;
  logic [6:0]   addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:15];
  logic [7:0] wq0[$], wq1[$], exp_q[$];
  logic       dv_q[$], rl_q[$];
  logic       stall, m_abort;
  logic [6:0] m_addr;

  i2c_txn_arbiter #(.LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .wr_next(wr_next),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .busy(busy),
    .addr(addr), .rw(rw), .tx_data(tx_data), .i2c_en(i2c_en),
    .data_valid(data_valid), .read_last(read_last), .data_next(data_next),
    .rx_data(rx_data), .ready(ready)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Requesters: present head of the byte queue, advance on wr_next
  initial begin
    req_wdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (wr_next[0] && wq0.size() > 0) void'(wq0.pop_front());
      if (wr_next[1] && wq1.size() > 0) void'(wq1.pop_front());
      #1;
      req_wdata = {(wq1.size() > 0) ? wq1[0] : 8'h00, (wq0.size() > 0) ? wq0[0] : 8'h00};
    end
  end

  // Master + slave model: accepts i2c_en, retires bytes every 2-4 cycles,
  // stops after a byte presented with data_valid low.
  initial begin
    int m_st;
    int gap;
    int ptr;
    logic m_rw;
    m_st = 0; gap = 0; ptr = 0; m_rw = 1'b0;
    ready = 1'b1; data_next = 1'b0; rx_data = 8'h00; m_addr = 7'h00;
    forever begin
      @(posedge clk);
      #1;
      data_next = 1'b0;
      if (rst) begin
        m_st = 0; ready = 1'b1;
      end else if (m_abort) begin
        m_st = 0; ready = 1'b1; m_abort = 1'b0;
      end else begin
        case (m_st)
          0: if (ready && i2c_en) begin
            ready = 1'b0; m_addr = addr; m_rw = rw; ptr = 0;
            gap = $urandom_range(1, 3); m_st = 1;
          end
          1: if (!stall) begin
            if (gap > 0) gap--;
            else begin
              data_next = 1'b1;
              if (m_rw) rx_data = mem[ptr & 15];
              else      mem[ptr & 15] = tx_data;
              dv_q.push_back(data_valid);
              rl_q.push_back(read_last);
              ptr++;
              gap = $urandom_range(1, 3);
              if (!data_valid) begin m_st = 2; gap = 2; end
            end
          end
          default: if (gap > 0) gap--; else begin ready = 1'b1; m_st = 0; end
        endcase
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_tests++; if ({busy, i2c_en, data_valid, read_last} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, i2c_en, data_valid, read_last}); end
    n_tests++; if ({addr, rw, tx_data, rd_data} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {addr, rw, tx_data, rd_data}); end
    n_tests++; if ({done, err, rd_valid, wr_next} !== 8'h0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0", {done, err, rd_valid, wr_next}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int nwr, ndone, cyc;
    logic seen_g;
    logic [3:0] dv_bits;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    wq0 = '{8'h00, 8'h0F, 8'hF0, 8'h55};
    exp_q = '{8'h00, 8'h0F, 8'hF0, 8'h55};
    dv_q.delete();
    req_addr[6:0] = 7'h50; req_rw[0] = 1'b0; req_len[3:0] = 4'd3; req[0] = 1'b1;
    nwr = 0; ndone = 0; seen_g = 1'b0;
    for (cyc = 0; cyc < 500 && ndone == 0; cyc++) begin
      @(negedge clk);
      if (!seen_g && gnt != 2'b00) begin
        seen_g = 1'b1;
        n_tests++; if ({gnt, addr, rw} !== {2'b01, 7'h50, 1'b0}) begin n_fail++; $display("FAIL write_grant: got gnt=%b addr=%h rw=%b expected 01/50/0", gnt, addr, rw); end
      end
      if (wr_next[0]) nwr++;
      if (done != 2'b00) begin
        ndone++; req[0] = 1'b0;
        n_tests++; if (done !== 2'b01) begin n_fail++; $display("FAIL write_done_dest: got %b expected 01", done); end
      end
    end
    repeat (4) begin @(negedge clk); if (done != 2'b00) ndone++; end
    n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL write_done_count: got %0d expected 1", ndone); end
    n_tests++; if (nwr !== 4) begin n_fail++; $display("FAIL write_wr_next_count: got %0d expected 4", nwr); end
    n_tests++; if (m_addr !== 7'h50) begin n_fail++; $display("FAIL write_slave_addr: got %h expected 50", m_addr); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (mem[i] !== exp_q[0]) begin n_fail++; $display("FAIL write_mem[%0d]: got %h expected %h", i, mem[i], exp_q[0]); end
      void'(exp_q.pop_front());
    end
    dv_bits = 4'b0000;
    foreach (dv_q[i]) if (i < 4) dv_bits[3-i] = dv_q[i];
    n_tests++; if (dv_q.size() != 4 || dv_bits !== 4'b1110) begin n_fail++; $display("FAIL write_data_valid: got %b (n=%0d) expected 1110", dv_bits, dv_q.size()); end
  endtask

  task automatic test_read();
    int nrd, ndone, cyc;
    logic [3:0] rl_bits;
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rl_q.delete();
    req_addr[13:7] = 7'h50; req_rw[1] = 1'b1; req_len[7:4] = 4'd3; req[1] = 1'b1;
    nrd = 0; ndone = 0;
    for (cyc = 0; cyc < 500 && ndone == 0; cyc++) begin
      @(negedge clk);
      if (rd_valid != 2'b00) begin
        nrd++;
        n_tests++;
        if (rd_valid !== 2'b10 || exp_q.size() == 0 || rd_data !== exp_q[0]) begin
          n_fail++; $display("FAIL read_byte%0d: got valid=%b data=%h expected 10/%h", nrd, rd_valid, rd_data, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (done != 2'b00) begin
        ndone++; req[1] = 1'b0;
        n_tests++; if (done !== 2'b10) begin n_fail++; $display("FAIL read_done_dest: got %b expected 10", done); end
      end
    end
    repeat (4) begin @(negedge clk); if (done != 2'b00 || rd_valid != 2'b00) ndone++; end
    n_tests++; if (ndone !== 1 || nrd !== 4) begin n_fail++; $display("FAIL read_counts: got done=%0d rd=%0d expected 1/4", ndone, nrd); end
    rl_bits = 4'b0000;
    foreach (rl_q[i]) if (i < 4) rl_bits[3-i] = rl_q[i];
    n_tests++; if (rl_q.size() != 4 || rl_bits !== 4'b0001) begin n_fail++; $display("FAIL read_last_pattern: got %b (n=%0d) expected 0001", rl_bits, rl_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int ngr, ndone, two_hot, cyc;
    logic [1:0] prev_g, last_g;
    logic prev_busy;
    wq0 = '{8'hA1, 8'hA2}; wq1 = '{8'hB1, 8'hB2};
    exp_q = '{8'h01, 8'h02, 8'h01, 8'h02};
    req_addr = {7'h20, 7'h10}; req_rw = 2'b00; req_len = 8'h00; req = 2'b11;
    ngr = 0; ndone = 0; two_hot = 0; prev_g = 2'b00; last_g = 2'b00; prev_busy = 1'b0;
    for (cyc = 0; cyc < 1000 && ndone < 4; cyc++) begin
      @(negedge clk);
      if ($countones(gnt) > 1) two_hot++;
      if (gnt != 2'b00 && prev_g == 2'b00) begin
        ngr++; last_g = gnt;
        n_tests++;
        if (prev_busy !== 1'b0 || exp_q.size() == 0 || {6'b0, gnt} !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_grant%0d: got gnt=%b prev_busy=%b expected %h with idle gap", ngr, gnt, prev_busy, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (ngr == 4) req = 2'b00;
      end
      if (done != 2'b00) begin
        ndone++;
        n_tests++; if (done !== last_g) begin n_fail++; $display("FAIL b2b_done%0d: got %b expected %b", ndone, done, last_g); end
      end
      prev_g = gnt; prev_busy = busy;
    end
    repeat (10) begin @(negedge clk); if (gnt != 2'b00) ngr++; if (done != 2'b00) ndone++; end
    n_tests++; if (ngr !== 4 || ndone !== 4) begin n_fail++; $display("FAIL b2b_counts: got grants=%0d dones=%0d expected 4/4", ngr, ndone); end
    n_tests++; if (two_hot !== 0) begin n_fail++; $display("FAIL b2b_two_hot: got %0d cycles expected 0", two_hot); end
    n_tests++; if (wq0.size() != 0 || wq1.size() != 0) begin n_fail++; $display("FAIL b2b_bytes_left: got %0d/%0d expected 0/0", wq0.size(), wq1.size()); end
    exp_q.delete();
  endtask

  task automatic test_read_len0();
    int nrd, ndone, dv_bad, cyc;
    logic seen_g;
    mem[0] = 8'h3C; exp_q = '{8'h3C};
    req_addr[6:0] = 7'h2A; req_rw[0] = 1'b1; req_len[3:0] = 4'd0; req[0] = 1'b1;
    nrd = 0; ndone = 0; dv_bad = 0; seen_g = 1'b0;
    for (cyc = 0; cyc < 500 && ndone == 0; cyc++) begin
      @(negedge clk);
      if (!seen_g && gnt != 2'b00) begin
        seen_g = 1'b1;
        n_tests++; if ({read_last, data_valid, i2c_en} !== 3'b101) begin n_fail++; $display("FAIL len0_start: got rl/dv/en=%b expected 101", {read_last, data_valid, i2c_en}); end
      end
      if (data_valid) dv_bad++;
      if (rd_valid != 2'b00) begin
        nrd++;
        n_tests++;
        if (rd_valid !== 2'b01 || exp_q.size() == 0 || rd_data !== exp_q[0]) begin
          n_fail++; $display("FAIL len0_byte: got valid=%b data=%h expected 01/3c", rd_valid, rd_data);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (done != 2'b00) begin ndone++; req[0] = 1'b0; end
    end
    repeat (4) begin @(negedge clk); if (rd_valid != 2'b00) nrd++; end
    n_tests++; if (ndone !== 1 || nrd !== 1 || dv_bad !== 0) begin n_fail++; $display("FAIL len0_counts: got done=%0d rd=%0d dv_high=%0d expected 1/1/0", ndone, nrd, dv_bad); end
    exp_q.delete();
  endtask

  task automatic test_timeout();
    int cyc, ndone, nerr;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    stall = 1'b1;
    wq1 = '{8'h77};
    req_addr[13:7] = 7'h22; req_rw[1] = 1'b0; req_len[7:4] = 4'd0; req[1] = 1'b1;
    for (cyc = 0; cyc < 100 && gnt == 2'b00; cyc++) @(negedge clk);
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL timeout_grant: got %b expected 10", gnt); end
    wq0 = '{8'h66};
    req_addr[6:0] = 7'h11; req_rw[0] = 1'b0; req_len[3:0] = 4'd0; req[0] = 1'b1;
    ndone = 0; nerr = 0;
    for (cyc = 0; cyc < 200 && nerr == 0; ) begin
      @(negedge clk);
      cyc++;
      if (done != 2'b00) ndone++;
      if (err != 2'b00) begin
        nerr++;
        // START takes one cycle before XFER entry restarts the watchdog.
        n_tests++; if (cyc !== TO + 1) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", cyc, TO + 1); end
        n_tests++; if ({err, gnt, busy, i2c_en} !== 6'b100000) begin n_fail++; $display("FAIL timeout_abort: got err/gnt/busy/en=%b expected 100000", {err, gnt, busy, i2c_en}); end
        req[1] = 1'b0; stall = 1'b0; m_abort = 1'b1;
      end
    end
    n_tests++; if (nerr !== 1 || ndone !== 0) begin n_fail++; $display("FAIL timeout_pulses: got err=%0d done=%0d expected 1/0", nerr, ndone); end
    for (cyc = 0; cyc < 100 && gnt == 2'b00; cyc++) @(negedge clk);
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL timeout_next_grant: got %b expected 01", gnt); end
    for (cyc = 0; cyc < 300 && ndone == 0; cyc++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        ndone++; req[0] = 1'b0;
        n_tests++; if (done !== 2'b01) begin n_fail++; $display("FAIL timeout_next_done: got %b expected 01", done); end
      end
    end
    n_tests++; if (ndone !== 1 || mem[0] !== 8'h66 || wq1.size() != 1) begin n_fail++; $display("FAIL timeout_recovery: got done=%0d mem0=%h left1=%0d expected 1/66/1", ndone, mem[0], wq1.size()); end
    wq1.delete();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nwr, ndone, nbad, cyc;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    wq0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    req_addr[6:0] = 7'h50; req_rw[0] = 1'b0; req_len[3:0] = 4'd3; req[0] = 1'b1;
    nwr = 0;
    for (cyc = 0; cyc < 300 && nwr == 0; cyc++) begin
      @(negedge clk);
      if (wr_next[0]) nwr++;
    end
    n_tests++; if (nwr !== 1) begin n_fail++; $display("FAIL rstmid_first_byte: got %0d expected 1", nwr); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if ({gnt, i2c_en, busy, data_valid, read_last} !== 6'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b expected 0", {gnt, i2c_en, busy, data_valid, read_last}); end
    n_tests++; if ({addr, rw, tx_data, done, err, rd_valid, wr_next} !== 24'h0) begin n_fail++; $display("FAIL rstmid_outs: got %h expected 0", {addr, rw, tx_data, done, err, rd_valid, wr_next}); end
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wq0.delete();
    nbad = 0;
    repeat (5) begin @(negedge clk); if (done != 2'b00 || err != 2'b00 || gnt != 2'b00) nbad++; end
    n_tests++; if (nbad !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", nbad); end
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    wq0 = '{8'h5A, 8'hA5};
    exp_q = '{8'h5A, 8'hA5};
    req_addr[6:0] = 7'h33; req_len[3:0] = 4'd1; req[0] = 1'b1;
    ndone = 0;
    for (cyc = 0; cyc < 500 && ndone == 0; cyc++) begin
      @(negedge clk);
      if (done != 2'b00) begin ndone++; req[0] = 1'b0; end
    end
    n_tests++; if (ndone !== 1 || m_addr !== 7'h33) begin n_fail++; $display("FAIL rstmid_fresh: got done=%0d addr=%h expected 1/33", ndone, m_addr); end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (mem[i] !== exp_q[0]) begin n_fail++; $display("FAIL rstmid_mem[%0d]: got %h expected %h", i, mem[i], exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; req_addr = 14'h0; req_rw = 2'b00; req_len = 8'h00;
    stall = 1'b0; m_abort = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_read_len0();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
